btn_bit_entry: RTL

BTN_BIT_ENTRY -- requirements
Module: btn_bit_entry

---
 rtl/btn_bit_entry_if.sv | 29 ++
 rtl/btn_bit_entry.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/btn_bit_entry_if.sv
// Button-entry bundle: raw buttons in, entered bit / strobe / status out.
interface btn_bit_entry_if;
  logic       btn0;
  logic       btn1;
  logic       d;
  logic       shift;
  logic       busy;
  logic [4:0] bit_count;

  // The entry block itself: samples the buttons, drives the checker side.
  modport slave (
    input  btn0,
    input  btn1,
    output d,
    output shift,
    output busy,
    output bit_count
  );

  // The environment: presses buttons, observes the strobe side.
  modport master (
    output btn0,
    output btn1,
    input  d,
    input  shift,
    input  busy,
    input  bit_count
  );
endinterface

// File: rtl/btn_bit_entry.sv
// Two-button bit entry: synchronizes and debounces btn0/btn1, turns a clean
// press into one setup/strobe cycle on d/shift for a shift-register checker.
module btn_bit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SETUP_CYCLES    = 4,
  parameter int unsigned STROBE_CYCLES   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  btn_bit_entry_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PH_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETUP_LAST  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0]  STROBE_LAST = PH_W'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Index 0 is btn0, index 1 is btn1 throughout.
  logic [1:0]            meta_q, sync_q;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            stable_q, stable_d;
  logic [1:0]            press_q, press_d;

  state_e                state_q, state_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic                  d_q, d_d;
  logic                  shift_q, shift_d;
  logic                  busy_q, busy_d;
  logic [4:0]            bc_q, bc_d;

  // Two-flop synchronizer for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {bus.btn1, bus.btn0};
      sync_q <= meta_q;
    end
  end

  // Per-button debounce: stable level follows sync only after a full run of disagreement.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      press_d[i] = stable_d[i] & ~stable_q[i];
    end
  end

  // Debounce counters, stable levels and one-cycle press events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 2'b00;
      press_q  <= 2'b00;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  // Entry sequencing: next state, phase count, and next values of all outputs.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (press_q == 2'b01) begin
          state_d = SETUP;
          d_d     = 1'b0;
          ph_d    = '0;
        end else if (press_q == 2'b10) begin
          state_d = SETUP;
          d_d     = 1'b1;
          ph_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (ph_q == SETUP_LAST) begin
          state_d = STROBE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      STROBE: begin
        if (ph_q == STROBE_LAST) begin
          state_d = HOLD;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      HOLD: begin
        // Wait for both buttons to be released so one press is one bit.
        if (stable_q == 2'b00) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
      end
    endcase

    shift_d = (state_d == STROBE);
    busy_d  = (state_d != IDLE);
    if ((state_q == SETUP) && (state_d == STROBE) && (bc_q != 5'd31)) begin
      bc_d = bc_q + 5'd1;
    end else begin
      bc_d = bc_q;
    end
  end

  // FSM state and registered outputs; reset kills any strobe in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      d_q     <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      bc_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      d_q     <= d_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      bc_q    <= bc_d;
    end
  end

  assign bus.d         = d_q;
  assign bus.shift     = shift_q;
  assign bus.busy      = busy_q;
  assign bus.bit_count = bc_q;

endmodule
